// File: rtl/pipeline_latch.sv
// pipeline_latch
//   Parametrised pipeline-stage register for the MIPS datapath. It adds a
//   valid/ready handshake and a synchronous flush that injects a bubble. With
//   SKID=1 it holds up to two entries so that o_ready can come from a flop.
//   With SKID=0 it is a single register and o_ready is combinational.
// Ports
//   i_clock  : clock, rising edge
//   i_reset  : synchronous, active-high reset (beats flush and all traffic)
//   i_data   : upstream data        i_valid : upstream data valid
//   o_ready  : stage accepts i_data this cycle
//   o_data   : registered data out  o_valid : o_data valid
//   i_ready  : downstream accepts o_data (low = stall)
//   i_flush  : discard all held entries; o_data returns to RESET_VALUE
//   o_count  : number of entries held (0..2, max 1 when SKID=0)
module pipeline_latch #(
  parameter int                    BUS_DATA    = 8,
  parameter bit                    SKID        = 1'b1,
  parameter logic [BUS_DATA-1:0]   RESET_VALUE = '0
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [BUS_DATA-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [BUS_DATA-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  input  logic                i_flush,
  output logic [1:0]          o_count
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  generate
    if (SKID) begin : g_skid
      localparam logic [1:0] EMPTY = 2'd0;
      localparam logic [1:0] BUSY  = 2'd1;
      localparam logic [1:0] FULL  = 2'd2;

      logic [1:0]          state_q, state_d;
      logic [BUS_DATA-1:0] main_q, skid_q;
      logic                ready_q;

      always_comb begin
        state_d = state_q;
        case (state_q)
          EMPTY: if (in_fire) state_d = BUSY;
          BUSY: begin
            if (in_fire && !out_fire)      state_d = FULL;
            else if (!in_fire && out_fire) state_d = EMPTY;
          end
          FULL:    if (out_fire) state_d = BUSY;
          default: state_d = EMPTY;
        endcase
      end

      always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
          state_q <= EMPTY;
          main_q  <= RESET_VALUE;
          skid_q  <= RESET_VALUE;
          ready_q <= 1'b1;
        end else begin
          state_q <= state_d;
          // Ready is precomputed from the next state so it is a pure flop.
          ready_q <= (state_d != FULL);
          case (state_q)
            EMPTY: if (in_fire) main_q <= i_data;
            BUSY: begin
              if (in_fire && out_fire) main_q <= i_data;
              else if (in_fire)        skid_q <= i_data;
            end
            FULL:    if (out_fire) main_q <= skid_q;
            default: ;
          endcase
        end
      end

      assign o_ready = ready_q;
      assign o_valid = (state_q != EMPTY);
      assign o_data  = main_q;
      assign o_count = (state_q == FULL) ? 2'd2 : (state_q == BUSY) ? 2'd1 : 2'd0;
    end else begin : g_single
      logic                valid_q;
      logic [BUS_DATA-1:0] main_q;

      always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
          valid_q <= 1'b0;
          main_q  <= RESET_VALUE;
        end else begin
          valid_q <= in_fire | (valid_q & ~i_ready);
          if (in_fire) main_q <= i_data;
        end
      end

      // Downstream ready passes straight through so a stalled word can be
      // replaced on the same edge it leaves.
      assign o_ready = ~valid_q | i_ready;
      assign o_valid = valid_q;
      assign o_data  = main_q;
      assign o_count = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_latch.sv
// Bench for pipeline_latch: one SKID=1 and one SKID=0 instance share stimulus;
// each is compared against a queue model of its capacity.
module tb_pipeline_latch;

  logic       i_clock = 1'b0;
  logic       i_reset, i_valid, i_ready, i_flush;
  logic [7:0] i_data;
  logic       rdy1, vld1, rdy0, vld0;
  logic [7:0] dat1, dat0;
  logic [1:0] cnt1, cnt0;

  int ncmp = 0;
  int nerr = 0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic [7:0] last1, last0;
  logic       exp_r1, exp_r0;

  always #5 i_clock = ~i_clock;

  pipeline_latch #(.BUS_DATA(8), .SKID(1'b1), .RESET_VALUE(8'h00)) dut1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy1), .o_data(dat1), .o_valid(vld1), .i_ready(i_ready),
    .i_flush(i_flush), .o_count(cnt1));

  pipeline_latch #(.BUS_DATA(8), .SKID(1'b0), .RESET_VALUE(8'h00)) dut0 (
    .i_clock(i_clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy0), .o_data(dat0), .o_valid(vld0), .i_ready(i_ready),
    .i_flush(i_flush), .o_count(cnt0));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs just after a falling edge, check ready before the
  // rising edge, advance the model, check outputs just after the rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r,
                       input logic fl, input logic rs, input logic armed);
    logic in1, in0, out1, out0;
    i_valid = v; i_data = d; i_ready = r; i_flush = fl; i_reset = rs;
    #1;
    exp_r1 = (q1.size() < 2);
    exp_r0 = (q0.size() == 0) || r;
    if (armed) begin
      chk("ready_skid1", 8'(rdy1), 8'(exp_r1));
      chk("ready_skid0", 8'(rdy0), 8'(exp_r0));
    end
    @(posedge i_clock);
    #1;
    if (rs || fl) begin
      q1.delete(); q0.delete();
      last1 = 8'h00; last0 = 8'h00;
    end else begin
      out1 = (q1.size() > 0) && r;
      out0 = (q0.size() > 0) && r;
      in1  = v && exp_r1;
      in0  = v && exp_r0;
      if (out1) void'(q1.pop_front());
      if (out0) void'(q0.pop_front());
      if (in1)  q1.push_back(d);
      if (in0)  q0.push_back(d);
      if (q1.size() > 0) last1 = q1[0];
      if (q0.size() > 0) last0 = q0[0];
    end
    chk("valid_skid1", 8'(vld1), 8'(q1.size() > 0));
    chk("data_skid1",  dat1, last1);
    chk("count_skid1", 8'(cnt1), 8'(q1.size()));
    chk("valid_skid0", 8'(vld0), 8'(q0.size() > 0));
    chk("data_skid0",  dat0, last0);
    chk("count_skid0", 8'(cnt0), 8'(q0.size()));
    @(negedge i_clock);
  endtask

  initial begin
    i_valid = 1'b0; i_data = 8'h00; i_ready = 1'b1; i_flush = 1'b0; i_reset = 1'b1;
    last1 = 8'h00; last0 = 8'h00;
    @(negedge i_clock);

    // reset with traffic present
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("reset_ready_skid1", 8'(rdy1), 8'h01);
    chk("reset_ready_skid0", 8'(rdy0), 8'h01);
    chk("reset_data_skid1", dat1, 8'h00);

    // back-to-back streaming
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("drain_keeps_data", dat1, 8'h10);

    // stall fills skid, 33 held upstream, then release
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_count", 8'(cnt1), 8'h02);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // flush while full, input 44 dropped
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_data", dat1, 8'h00);

    // simultaneous in/out while busy
    cycle(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("busy_passthru", dat1, 8'h55);

    // single-register stall then combinational release
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("skid0_reload", dat0, 8'h88);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 99) == 0), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
